// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared processor defines for the pipeline hazard controller:
// FSM state encoding, memory timeout default and the control-output bundle.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

   // Pipeline control outputs as a single bundle.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic ifid_flush;
      logic idex_bubble;
      logic memwb_bubble;
      logic fault;
   } ctrl_t;

   // Normal cycle: everything advances, nothing is squashed.
   localparam ctrl_t CTRL_NORMAL = '{
      pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
      ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0, fault: 1'b0
   };

   // Whole pipeline frozen behind MEM, with a bubble launched into WB.
   localparam ctrl_t CTRL_FROZEN = '{
      pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
      ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b1, fault: 1'b0
   };

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID is about to read. Purely combinational.
module hazard_detect (
   input  logic       EX_MemRead,
   input  logic [4:0] EX_RegRd,
   input  logic [4:0] ID_RegRs1,
   input  logic [4:0] ID_RegRs2,
   input  logic       ID_UsesRs2,
   output logic       load_use
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = (EX_RegRd == ID_RegRs1);
   assign rs2_match = ID_UsesRs2 && (EX_RegRd == ID_RegRs2);
   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use  = EX_MemRead && (EX_RegRd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-stall FSM with timeout fault,
// branch flush, load-use stall and saturating performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_RegRs1,
   input  logic [4:0]       ID_RegRs2,
   input  logic             ID_UsesRs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_RegRd,
   input  logic             EX_BranchTaken,
   input  logic             MEM_MemAccess,
   input  logic             dmem_ready,
   output logic             PC_en,
   output logic             IFID_en,
   output logic             IDEX_en,
   output logic             EXMEM_en,
   output logic             IFID_flush,
   output logic             IDEX_bubble,
   output logic             MEMWB_bubble,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   state_t            state;
   state_t            next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_stall;
   logic              load_use;
   ctrl_t             ctrl;

   assign mem_stall = MEM_MemAccess && !dmem_ready;

   hazard_detect u_hazard_detect (
      .EX_MemRead (EX_MemRead),
      .EX_RegRd   (EX_RegRd),
      .ID_RegRs1  (ID_RegRs1),
      .ID_RegRs2  (ID_RegRs2),
      .ID_UsesRs2 (ID_UsesRs2),
      .load_use   (load_use)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= next_state;
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         RUN: begin
            if (mem_stall) next_state = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready)               next_state = RUN;
            else if (wait_cnt == WAIT_LIMIT) next_state = FAULT;
         end
         FAULT:   next_state = FAULT;
         default: next_state = RUN;
      endcase
   end

   // Output decode; reset forces the RUN no-event decode regardless of state.
   always_comb begin
      ctrl = CTRL_NORMAL;
      if (!rst) begin
         case (state)
            RUN: begin
               if (mem_stall) begin
                  ctrl = CTRL_FROZEN;
               end else if (EX_BranchTaken) begin
                  ctrl.ifid_flush  = 1'b1;
                  ctrl.idex_bubble = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en       = 1'b0;
                  ctrl.ifid_en     = 1'b0;
                  ctrl.idex_bubble = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!dmem_ready) ctrl = CTRL_FROZEN;
            end
            FAULT: begin
               ctrl       = CTRL_FROZEN;
               ctrl.fault = 1'b1;
            end
            default: ctrl = CTRL_NORMAL;
         endcase
      end
   end

   assign PC_en        = ctrl.pc_en;
   assign IFID_en      = ctrl.ifid_en;
   assign IDEX_en      = ctrl.idex_en;
   assign EXMEM_en     = ctrl.exmem_en;
   assign IFID_flush   = ctrl.ifid_flush;
   assign IDEX_bubble  = ctrl.idex_bubble;
   assign MEMWB_bubble = ctrl.memwb_bubble;
   assign fault        = ctrl.fault;

   // Wait counter: held at zero in RUN so every MEM_WAIT entry starts fresh.
   always_ff @(posedge clk) begin
      if (rst || state == RUN) begin
         wait_cnt <= '0;
      end else if (state == MEM_WAIT && !dmem_ready && wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Saturating stall counter: frozen PC outside FAULT.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!ctrl.pc_en && state != FAULT && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Saturating flush counter: one count per IF/ID flush cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= '0;
      end else if (ctrl.ifid_flush && flush_cnt != '1) begin
         flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses2;
      logic       memread;
      logic [4:0] rd;
      logic       br;
      logic       memacc;
      logic       ready;
   } in_t;

   typedef struct {
      in_t        in;
      logic [7:0] exp;
   } vec_t;

   // {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_bubble, MEMWB_bubble, fault}
   localparam logic [7:0] O_NORM = 8'b1111_0000;
   localparam logic [7:0] O_LU   = 8'b0011_0100;
   localparam logic [7:0] O_BR   = 8'b1111_1100;
   localparam logic [7:0] O_FRZ  = 8'b0000_0010;
   localparam logic [7:0] O_FLT  = 8'b0000_0011;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_RegRs1, ID_RegRs2, EX_RegRd;
   logic       ID_UsesRs2, EX_MemRead, EX_BranchTaken, MEM_MemAccess, dmem_ready;
   logic       PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_bubble, MEMWB_bubble, fault;
   logic [3:0] stall_cnt, flush_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   vec_t vecs[10];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_RegRs1      (ID_RegRs1),
      .ID_RegRs2      (ID_RegRs2),
      .ID_UsesRs2     (ID_UsesRs2),
      .EX_MemRead     (EX_MemRead),
      .EX_RegRd       (EX_RegRd),
      .EX_BranchTaken (EX_BranchTaken),
      .MEM_MemAccess  (MEM_MemAccess),
      .dmem_ready     (dmem_ready),
      .PC_en          (PC_en),
      .IFID_en        (IFID_en),
      .IDEX_en        (IDEX_en),
      .EXMEM_en       (EXMEM_en),
      .IFID_flush     (IFID_flush),
      .IDEX_bubble    (IDEX_bubble),
      .MEMWB_bubble   (MEMWB_bubble),
      .fault          (fault),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                              input logic memread, input logic [4:0] rd, input logic br,
                              input logic memacc, input logic ready);
      in_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.uses2 = uses2; v.memread = memread;
      v.rd = rd; v.br = br; v.memacc = memacc; v.ready = ready;
      return v;
   endfunction

   task automatic drive(input in_t v);
      ID_RegRs1      = v.rs1;
      ID_RegRs2      = v.rs2;
      ID_UsesRs2     = v.uses2;
      EX_MemRead     = v.memread;
      EX_RegRd       = v.rd;
      EX_BranchTaken = v.br;
      MEM_MemAccess  = v.memacc;
      dmem_ready     = v.ready;
   endtask

   task automatic check_ctrl(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_bubble, MEMWB_bubble, fault};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ctrl: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_cnt(input string name, input logic [3:0] got, input int unsigned exp);
      n_tests++;
      if (got !== 4'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One clock: apply inputs, check the combinational decode, advance, check counters.
   task automatic step(input string name, input in_t v, input logic [7:0] exp);
      drive(v);
      #2;
      check_ctrl(name, exp);
      if (!exp[7] && !exp[0] && exp_stall < 15) exp_stall++;
      if (exp[3] && exp_flush < 15) exp_flush++;
      @(posedge clk);
      #1;
      check_cnt({name, " stall_cnt"}, stall_cnt, exp_stall);
      check_cnt({name, " flush_cnt"}, flush_cnt, exp_flush);
   endtask

   // One reset cycle with a load-use hazard on the inputs to show reset overrides decode.
   task automatic do_reset(input string name);
      rst = 1'b1;
      drive(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0));
      #2;
      check_ctrl({name, " during rst"}, O_NORM);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      check_cnt({name, " stall_cnt"}, stall_cnt, 0);
      check_cnt({name, " flush_cnt"}, flush_cnt, 0);
   endtask

   initial begin
      in_t idle, lu, br, mstall, mready;
      idle   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      lu     = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      br     = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      mstall = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      mready = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);

      vecs[0] = '{idle, O_NORM};
      vecs[1] = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1), O_LU};   // rs1 load-use
      vecs[2] = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1), O_NORM}; // rd = x0
      vecs[3] = '{mk(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1), O_NORM}; // rs2 not read
      vecs[4] = '{mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1), O_LU};   // rs2 load-use
      vecs[5] = '{mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1), O_BR};   // branch beats load-use
      vecs[6] = '{br, O_BR};
      vecs[7] = '{mk(5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1), O_NORM}; // not a load
      vecs[8] = '{mk(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1), O_LU};   // mem ready, load-use
      vecs[9] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1), O_BR};   // mem ready, branch

      rst = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset_init");

      for (int i = 0; i < 10; i++) begin
         step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
      end

      // Three memory-stall cycles then ready; MEM_WAIT ignores branch and MemAccess.
      do_reset("reset_memstall");
      step("mem_c1", mstall, O_FRZ);
      step("mem_c2", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), O_FRZ);
      step("mem_c3", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), O_FRZ);
      step("mem_release", mready, O_NORM);
      step("mem_back_run", lu, O_LU);
      check_cnt("mem_total_stall", stall_cnt, 4);

      // Ready arriving exactly on the last allowed wait cycle avoids the fault.
      do_reset("reset_edge");
      for (int i = 0; i < 5; i++) step($sformatf("edge_w%0d", i), mstall, O_FRZ);
      step("edge_ready", mready, O_NORM);
      step("edge_run", lu, O_LU);

      // Timeout: RUN stall cycle + wait counts 0..4, then FAULT ignores inputs.
      do_reset("reset_timeout");
      for (int i = 0; i < 6; i++) step($sformatf("to_w%0d", i), mstall, O_FRZ);
      step("fault_1", mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1), O_FLT);
      step("fault_2", idle, O_FLT);
      check_cnt("fault_stall_frozen", stall_cnt, 6);
      do_reset("reset_from_fault");
      step("after_fault", lu, O_LU);

      // Reset taken while in MEM_WAIT.
      do_reset("reset_pre_mw");
      step("mw_a", mstall, O_FRZ);
      step("mw_b", mstall, O_FRZ);
      do_reset("reset_in_mw");
      step("mw_after", lu, O_LU);

      // Saturation of both 4-bit counters.
      do_reset("reset_sat");
      for (int i = 0; i < 20; i++) step($sformatf("sat_lu%0d", i), lu, O_LU);
      check_cnt("stall_saturated", stall_cnt, 15);
      for (int i = 0; i < 20; i++) step($sformatf("sat_br%0d", i), br, O_BR);
      check_cnt("flush_saturated", flush_cnt, 15);
      check_cnt("stall_held", stall_cnt, 15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
